// File: rtl/dmem_responder.sv
// Single-port data memory responder: valid/ready request in, one response per transaction out.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_wbyteen,
  input  logic [1:0]  req_rbyteen,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          out_of_range;
  logic          size_bad;
  logic          is_half;
  logic          is_word;
  logic          req_err;
  logic [1:0]    req_lane;
  logic [AW-1:0] req_idx;
  logic [3:0]    wmask;
  logic [31:0]   wdata_sh;
  logic          wr_en;

  logic [AW-1:0] ld_idx_p0;
  logic [1:0]    ld_lane_p0;
  logic [1:0]    ld_size_p0;
  logic          ld_uns_p0;
  logic          ld_err_p0;

  logic [31:0]   rdata_nxt;
  logic          err_nxt;

  // Select the addressed byte/half and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic        [31:0] r;
    b  = word[{lane, 3'b000} +: 8];
    h  = lane[1] ? word[31:16] : word[15:0];
    bs = b;
    hs = h;
    case (size)
      2'b00:   r = uns ? 32'(b) : 32'(bs);
      2'b01:   r = uns ? 32'(h) : 32'(hs);
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // Request decode: legality, effective lane and word index
  always_comb begin
    out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
    if (req_we) begin
      size_bad = !((req_wbyteen == 4'b0001) || (req_wbyteen == 4'b0011) ||
                   (req_wbyteen == 4'b1111));
      is_half  = (req_wbyteen == 4'b0011);
      is_word  = (req_wbyteen == 4'b1111);
    end else begin
      size_bad = (req_rbyteen == 2'b11);
      is_half  = (req_rbyteen == 2'b01);
      is_word  = (req_rbyteen == 2'b10);
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    req_err  = out_of_range || size_bad ||
               (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    req_lane = req_addr[1:0];
`else
    req_err  = out_of_range || size_bad;
    if (is_word)
      req_lane = 2'b00;
    else if (is_half)
      req_lane = {req_addr[1], 1'b0};
    else
      req_lane = req_addr[1:0];
`endif
    req_idx  = req_addr[AW+1:2];
    wmask    = 4'(req_wbyteen << req_lane);
    wdata_sh = req_wdata << {req_lane, 3'b000};
    wr_en    = accept && req_we && !req_err;
  end

  // Stores commit on the acceptance edge; the array is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b])
          mem[req_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Stage p0: load attributes captured at acceptance
  always_ff @(posedge clk) begin
    if (accept && !req_we) begin
      ld_idx_p0  <= req_idx;
      ld_lane_p0 <= req_lane;
      ld_size_p0 <= req_rbyteen;
      ld_uns_p0  <= req_unsigned;
      ld_err_p0  <= req_err;
    end
  end

  // Stage p1: registered array read and response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rdata_nxt = rsp_rdata;
    err_nxt   = rsp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_we ? RESP : READ;
          rdata_nxt = 32'd0;
          err_nxt   = req_err;
        end
      end
      READ: begin
        state_nxt = RESP;
        err_nxt   = ld_err_p0;
        rdata_nxt = ld_err_p0 ? 32'd0 :
                    load_extend(mem[ld_idx_p0], ld_lane_p0, ld_size_p0, ld_uns_p0);
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
          rdata_nxt = 32'd0;
          err_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        rdata_nxt = 32'd0;
        err_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-addressed reference model and a per-cycle checker.
module tb_dmem_responder;

  localparam int TB_DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wbyteen;
  logic [1:0]  req_rbyteen;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mb [0:4*TB_DEPTH-1];

  bit          armed = 0;
  bit          done  = 0;
  int          age   = 0;
  int          exp_lat;
  logic [31:0] exp_rdata;
  bit          exp_err;

  dmem_responder #(.DEPTH_WORDS(TB_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wbyteen  (req_wbyteen),
    .req_rbyteen  (req_rbyteen),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: memory as a byte array, access size in bytes, plain arithmetic extension.
  task automatic model_req(input bit we, input logic [31:0] addr, input logic [3:0] wbe,
                           input logic [1:0] rbe, input bit uns, input logic [31:0] wd,
                           output logic [31:0] rd, output bit err);
    int sz;
    int ea;
    longint v;
    rd  = 32'd0;
    err = 0;
    if (we) sz = (wbe == 4'b0001) ? 1 : (wbe == 4'b0011) ? 2 : (wbe == 4'b1111) ? 4 : 0;
    else    sz = (rbe == 2'd0) ? 1 : (rbe == 2'd1) ? 2 : (rbe == 2'd2) ? 4 : 0;
    if (sz == 0 || addr >= 32'(4*TB_DEPTH)) begin
      err = 1;
      return;
    end
    ea = int'(addr);
    if (ea % sz != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      err = 1;
      return;
`else
      ea = ea - (ea % sz);
`endif
    end
    if (we) begin
      for (int i = 0; i < sz; i++) mb[ea+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v + (longint'(mb[ea+i]) << (8*i));
      if (!uns && sz < 4 && v[8*sz-1]) v = v - (64'sd1 <<< (8*sz));
      rd = v[31:0];
    end
  endtask

  // Per-cycle checker: age counts negedges since the request was driven.
  always @(negedge clk) begin
    if (armed) begin
      if (age == 0) begin
        check("accept_ready", 32'(req_ready), 32'd1);
        check("idle_no_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        check("busy_not_ready", 32'(req_ready), 32'd0);
        check("rsp_valid_timing", 32'(rsp_valid), 32'(age >= exp_lat));
        if (rsp_valid) begin
          check("rsp_rdata", rsp_rdata, exp_rdata);
          check("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
        if (rsp_valid && rsp_ready) begin
          armed = 0;
          done  = 1;
        end else if (age > 40) begin
          check("rsp_timeout", 32'(age), 32'(exp_lat));
          armed = 0;
          done  = 1;
        end
      end
      age++;
    end
  end

  task automatic do_req(input string name, input bit sync, input bit we,
                        input logic [31:0] addr, input logic [3:0] wbe, input logic [1:0] rbe,
                        input bit uns, input logic [31:0] wd, input int hold,
                        input logic [31:0] lit_rd, input bit lit_err);
    logic [31:0] rd;
    bit e;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    model_req(we, addr, wbe, rbe, uns, wd, rd, e);
    check({name, "_model_rdata"}, rd, lit_rd);
    check({name, "_model_err"}, 32'(e), 32'(lit_err));
    exp_rdata    = rd;
    exp_err      = e;
    exp_lat      = we ? 1 : 2;
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wbyteen  = wbe;
    req_rbyteen  = rbe;
    req_unsigned = uns;
    req_wdata    = wd;
    rsp_ready    = (hold == 0);
    done         = 0;
    age          = 0;
    armed        = 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (hold > 0) begin
      repeat (exp_lat + hold - 1) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    for (int i = 0; i < 60 && !done; i++) @(posedge clk);
    if (!done) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
      armed = 0;
    end
  endtask

  task automatic st(input string name, input logic [31:0] addr, input logic [3:0] wbe,
                    input logic [31:0] wd, input bit lit_err);
    do_req(name, 1, 1, addr, wbe, 2'd0, 0, wd, 0, 32'd0, lit_err);
  endtask

  task automatic ld(input string name, input logic [31:0] addr, input logic [1:0] rbe,
                    input bit uns, input logic [31:0] lit_rd, input bit lit_err,
                    input int hold = 0);
    do_req(name, 1, 0, addr, 4'b0000, rbe, uns, 32'd0, hold, lit_rd, lit_err);
  endtask

  // Reset strikes one cycle after acceptance (load in READ, store in RESP).
  task automatic reset_during(input string name, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd);
    logic [31:0] rd;
    bit e;
    @(posedge clk);
    #1;
    model_req(we, addr, 4'b1111, 2'd2, 0, wd, rd, e);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wbyteen  = 4'b1111;
    req_rbyteen  = 2'd2;
    req_unsigned = 1'b0;
    req_wdata    = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check({name, "_rst_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_rst_rdata"}, rsp_rdata, 32'd0);
    check({name, "_rst_err"}, 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check({name, "_rel_ready"}, 32'(req_ready), 32'd1);
    check({name, "_rel_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'd0;
    req_we       = 1'b0;
    req_wbyteen  = 4'd0;
    req_rbyteen  = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'd0;
    rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    #1 check("reset_ready", 32'(req_ready), 32'd1);

    st("st_w10", 32'h10, 4'b1111, 32'hDEADBEEF, 0);
    ld("ld_w10", 32'h10, 2'd2, 0, 32'hDEADBEEF, 0);
    st("st_b13", 32'h13, 4'b0001, 32'h00000080, 0);
    ld("ld_bs13", 32'h13, 2'd0, 0, 32'hFFFFFF80, 0);
    ld("ld_bu13", 32'h13, 2'd0, 1, 32'h00000080, 0);
    ld("ld_w10b", 32'h10, 2'd2, 0, 32'h80ADBEEF, 0);
    ld("ld_bs11", 32'h11, 2'd0, 0, 32'hFFFFFFBE, 0);
    st("st_w20", 32'h20, 4'b1111, 32'h00000000, 0);
    st("st_h22", 32'h22, 4'b0011, 32'h00001234, 0);
    ld("ld_hs22", 32'h22, 2'd1, 0, 32'h00001234, 0);
    ld("ld_w20", 32'h20, 2'd2, 0, 32'h12340000, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    ld("ld_w11_mis", 32'h11, 2'd2, 0, 32'h00000000, 1);
`else
    ld("ld_w11_mis", 32'h11, 2'd2, 0, 32'h80ADBEEF, 0);
`endif
    ld("ld_w10_hold", 32'h10, 2'd2, 0, 32'h80ADBEEF, 0, 5);
    st("st_w00", 32'h00, 4'b1111, 32'hCAFEF00D, 0);
    st("st_oob", 32'h100, 4'b1111, 32'h00000055, 1);
    ld("ld_w00_a", 32'h00, 2'd2, 0, 32'hCAFEF00D, 0);
    st("st_badmask", 32'h00, 4'b0101, 32'h00000077, 1);
    ld("ld_w00_b", 32'h00, 2'd2, 0, 32'hCAFEF00D, 0);
    ld("ld_badsize", 32'h00, 2'd3, 0, 32'h00000000, 1);
    ld("ld_oob", 32'h100, 2'd0, 0, 32'h00000000, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    st("st_h23_mis", 32'h23, 4'b0011, 32'h0000ABCD, 1);
    ld("ld_w20_after", 32'h20, 2'd2, 0, 32'h12340000, 0);
    ld("ld_hs22_after", 32'h22, 2'd1, 0, 32'h00001234, 0);
`else
    st("st_h23_mis", 32'h23, 4'b0011, 32'h0000ABCD, 0);
    ld("ld_w20_after", 32'h20, 2'd2, 0, 32'hABCD0000, 0);
    ld("ld_hs22_after", 32'h22, 2'd1, 0, 32'hFFFFABCD, 0);
`endif

    reset_during("rst_store", 1, 32'h30, 32'h11223344);
    do_req("ld_w30_first", 0, 0, 32'h30, 4'b0000, 2'd2, 0, 32'd0, 0, 32'h11223344, 0);
    reset_during("rst_load", 0, 32'h10, 32'd0);
    do_req("ld_w10_first", 0, 0, 32'h10, 4'b0000, 2'd2, 0, 32'd0, 0, 32'h80ADBEEF, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, power of two; number of 32-bit words in the data memory array.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  request present.
REQ-005 Port: req_ready  out  1  responder can accept a request.
REQ-006 Port: req_addr  in  32  byte address.
REQ-007 Port: req_we  in  1  1 = store, 0 = load.
REQ-008 Port: req_wbyteen  in  4  store size mask, unshifted: 0001 byte, 0011 half, 1111 word.
REQ-009 Port: req_rbyteen  in  2  load size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 Port: req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-011 Port: req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port: rsp_valid  out  1  response present.
REQ-013 Port: rsp_ready  in  1  consumer accepts response.
REQ-014 Port: rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-015 Port: rsp_err  out  1  request was illegal and had no memory effect.

Function
REQ-016 FSM states SHALL be IDLE, READ, RESP; req_ready = 1 only in IDLE.
REQ-017 Request accepted on a rising edge with req_valid && req_ready.
REQ-018 IDLE + accepted store: legal bytes written at that same edge; next state RESP.
REQ-019 IDLE + accepted load: address/size/unsigned captured; next state READ.
REQ-020 READ: registered array read of the captured word; next state RESP.
REQ-021 RESP: rsp_valid = 1; rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready, then IDLE.
REQ-022 Latency with rsp_ready tied high: store rsp_valid 1 cycle after acceptance, load 2 cycles; one transaction outstanding at most.
REQ-023 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; store mask shifted left by req_addr[1:0], data shifted by 8*req_addr[1:0].
REQ-024 Load byte lane = addr[1:0], half lane = addr[1]; result sign- or zero-extended per req_unsigned; word passes unchanged.
REQ-025 req_addr >= 4*DEPTH_WORDS: rsp_err = 1, no write, rsp_rdata = 0.
REQ-026 req_wbyteen not in {0001, 0011, 1111} on a store, or req_rbyteen = 11 on a load: rsp_err = 1, no write, rsp_rdata = 0.
REQ-027 Misaligned access (half with addr[0] = 1, word with addr[1:0] != 0) handled per REQ-032/REQ-033.
REQ-028 Memory array SHALL not be reset; contents persist across rst_n.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1 after release.
REQ-030 Reset during READ or RESP SHALL drop the transaction with no response; a store already written at acceptance remains written.
REQ-031 First request may be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 With DMEM_MISALIGN_TRAP_EN defined: misaligned access gives rsp_err = 1, no write, rsp_rdata = 0.
REQ-033 Without DMEM_MISALIGN_TRAP_EN: misaligned address forced aligned (half clears addr[0], word clears addr[1:0]); access proceeds, rsp_err = 0.

Verification
REQ-034 Store word 0xDEADBEEF at 0x10, load word 0x10 -> rdata 0xDEADBEEF, err 0; load ack'd exactly 2 cycles after acceptance.
REQ-035 Store byte 0x80 at 0x13, load byte signed 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word 0x10 -> 0x80ADBEEF.
REQ-036 Store half 0x1234 at 0x22 over word 0; load half signed 0x22 -> 0x00001234; load word 0x20 -> 0x12340000.
REQ-037 Load word at 0x11: with DMEM_MISALIGN_TRAP_EN -> err 1, rdata 0; without -> rdata = word at 0x10, err 0.
REQ-038 Load with rsp_ready low 5 cycles -> rsp_valid/rdata stable, req_ready 0 throughout; store to 4*DEPTH_WORDS -> err 1, no write.
REQ-039 rst_n asserted in READ -> rsp_valid 0 immediately; after release, req_ready 1 and earlier stored data still readable.
